xosera_bus_frontend: RTL

XOSERA_BUS_FRONTEND -- requirements
Module: xosera_bus_frontend

---
 rtl/xosera_bus_frontend.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/xosera_bus_frontend.sv
// Asynchronous host-bus front end: synchronises the bus pins, turns each chip-select
// edge into one core write strobe or read request, and answers the host with DTACK.
`timescale 1ns/1ps
module xosera_bus_frontend #(
    parameter int DATA_W      = 8,
    parameter int REG_W       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DTACK_DELAY = 0,
    parameter int RD_TIMEOUT  = 8
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              bus_cs_n_i,
    input  logic              bus_rd_nwr_i,
    input  logic              bus_bytesel_i,
    input  logic [REG_W-1:0]  bus_reg_num_i,
    input  logic [DATA_W-1:0] bus_data_i,
    output logic [DATA_W-1:0] bus_data_o,
    output logic              bus_out_ena_o,
    output logic              bus_dtack_n_o,
    output logic [REG_W-1:0]  reg_num_o,
    output logic              bytesel_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              wr_strobe_o,
    output logic              rd_req_o,
    input  logic [DATA_W-1:0] rd_data_i,
    input  logic              rd_valid_i,
    output logic              timeout_o
);

    localparam int IN_W    = 3 + REG_W + DATA_W;
    localparam int CNT_MAX = (DTACK_DELAY > RD_TIMEOUT) ? DTACK_DELAY : RD_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DTACK_DELAY);
    // Last WAIT_RD count so the timeout pulse lands RD_TIMEOUT cycles after rd_req_o.
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'((RD_TIMEOUT > 1) ? (RD_TIMEOUT - 2) : 0);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCESS  = 3'd1,
        S_WAIT_RD = 3'd2,
        S_DELAY   = 3'd3,
        S_ACK     = 3'd4
    } state_t;

    logic [IN_W-1:0]        sync_q [SYNC_STAGES];
    logic [IN_W-1:0]        sync_d [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill_q, fill_d;
    logic [IN_W-1:0]        sync_out;
    logic                   cs_sync, rd_nwr_sync, bytesel_sync;
    logic [REG_W-1:0]       reg_sync;
    logic [DATA_W-1:0]      data_sync;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   prev_cs_q, prev_cs_d;
    logic                   rd_nwr_q, rd_nwr_d;
    logic [REG_W-1:0]       reg_num_q, reg_num_d;
    logic                   bytesel_q, bytesel_d;
    logic [DATA_W-1:0]      wr_data_q, wr_data_d;
    logic [DATA_W-1:0]      bus_data_q, bus_data_d;
    logic                   wr_strobe_q, wr_strobe_d;
    logic                   rd_req_q, rd_req_d;
    logic                   timeout_q, timeout_d;
    logic                   dtack_n_q, dtack_n_d;
    logic                   read_active_q, read_active_d;

    assign sync_out     = sync_q[SYNC_STAGES-1];
    assign cs_sync      = sync_out[0];
    assign rd_nwr_sync  = sync_out[1];
    assign bytesel_sync = sync_out[2];
    assign reg_sync     = sync_out[3 +: REG_W];
    assign data_sync    = sync_out[3 + REG_W +: DATA_W];

    // Synchroniser shift and fill tracking (the chain holds reset values until filled).
    always_comb begin
        sync_d[0] = {bus_data_i, bus_reg_num_i, bus_bytesel_i, bus_rd_nwr_i, bus_cs_n_i};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        fill_d = {fill_q[SYNC_STAGES-2:0], 1'b1};
    end

    // Transaction FSM: next state, counters, latches and registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rd_nwr_d    = rd_nwr_q;
        reg_num_d   = reg_num_q;
        bytesel_d   = bytesel_q;
        wr_data_d   = wr_data_q;
        bus_data_d  = bus_data_q;
        wr_strobe_d = 1'b0;
        rd_req_d    = 1'b0;
        timeout_d   = 1'b0;
        dtack_n_d   = 1'b1;
        // A stale reset value in the chain must never look like a high-to-low edge.
        prev_cs_d   = cs_sync & fill_q[SYNC_STAGES-1];

        case (state_q)
            S_IDLE: begin
                if (!cs_sync && prev_cs_q) begin
                    rd_nwr_d    = rd_nwr_sync;
                    reg_num_d   = reg_sync;
                    bytesel_d   = bytesel_sync;
                    wr_data_d   = data_sync;
                    wr_strobe_d = ~rd_nwr_sync;
                    rd_req_d    = rd_nwr_sync;
                    cnt_d       = '0;
                    state_d     = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCESS: begin
                cnt_d = '0;
                if (cs_sync) begin
                    state_d = S_IDLE;
                end else if (rd_nwr_q) begin
                    state_d = S_WAIT_RD;
                end else begin
                    state_d = S_DELAY;
                end
            end
            S_WAIT_RD: begin
                if (cs_sync) begin
                    state_d = S_IDLE;
                end else if (rd_valid_i) begin
                    bus_data_d = rd_data_i;
                    cnt_d      = '0;
                    state_d    = S_DELAY;
                end else if (cnt_q == TO_LAST) begin
                    bus_data_d = '1;
                    timeout_d  = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_DELAY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DELAY: begin
                if (cs_sync) begin
                    state_d = S_IDLE;
                end else if (cnt_q == DLY_LAST) begin
                    dtack_n_d = 1'b0;
                    state_d   = S_ACK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ACK: begin
                if (cs_sync) begin
                    state_d = S_IDLE;
                end else begin
                    dtack_n_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        read_active_d = rd_nwr_d && ((state_d == S_DELAY) || (state_d == S_ACK));
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '1;
            end
            fill_q        <= '0;
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            prev_cs_q     <= 1'b0;
            rd_nwr_q      <= 1'b0;
            reg_num_q     <= '0;
            bytesel_q     <= 1'b0;
            wr_data_q     <= '0;
            bus_data_q    <= '0;
            wr_strobe_q   <= 1'b0;
            rd_req_q      <= 1'b0;
            timeout_q     <= 1'b0;
            dtack_n_q     <= 1'b1;
            read_active_q <= 1'b0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            fill_q        <= fill_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            prev_cs_q     <= prev_cs_d;
            rd_nwr_q      <= rd_nwr_d;
            reg_num_q     <= reg_num_d;
            bytesel_q     <= bytesel_d;
            wr_data_q     <= wr_data_d;
            bus_data_q    <= bus_data_d;
            wr_strobe_q   <= wr_strobe_d;
            rd_req_q      <= rd_req_d;
            timeout_q     <= timeout_d;
            dtack_n_q     <= dtack_n_d;
            read_active_q <= read_active_d;
        end
    end

    // Raw pin terms let the data drivers release the moment the host drops CS.
    assign bus_out_ena_o = read_active_q & ~bus_cs_n_i & bus_rd_nwr_i;
    assign bus_data_o    = bus_data_q;
    assign bus_dtack_n_o = dtack_n_q;
    assign reg_num_o     = reg_num_q;
    assign bytesel_o     = bytesel_q;
    assign wr_data_o     = wr_data_q;
    assign wr_strobe_o   = wr_strobe_q;
    assign rd_req_o      = rd_req_q;
    assign timeout_o     = timeout_q;

endmodule
